// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencing for the 5-stage IF/ID/EX/MEM/WB core.
//   It keeps a small history of the instructions in EX, MEM and WB and checks
//   the ID instruction for read-after-write hazards against that history.
//   From this it drives the PC and IF/ID enables, ID/EX bubbles, branch
//   flushes and the ALU forwarding-mux selects.
//   Hazard stall cycles are counted in a saturating performance counter.
//
// Parameters
//   FORWARD_EN  1: forward from EX/MEM/WB and stall only on load-use
//               0: no forwarding, interlock on EX or MEM producers
//   CNT_W       width of stall_cnt
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous, active-high reset
//   id_instr     in   16     ID instruction: opcode[15:12] rd[11:9] rs[8:6] rt[5:3]
//   id_valid     in   1      id_instr holds a real instruction
//   ex_br_taken  in   1      branch in EX resolved taken this cycle
//   ext_stall    in   1      memory wait, freezes the whole pipeline
//   pc_en        out  1      PC load enable
//   ifid_en      out  1      IF/ID load enable
//   ifid_flush   out  1      clear IF/ID to NOP
//   idex_bubble  out  1      load a NOP into ID/EX
//   fwd_a_sel    out  2      ALU src A: 00 RF, 01 EX/MEM, 10 MEM/WB, 11 WB result
//   fwd_b_sel    out  2      ALU src B / store data, same encoding
//   stall_cnt    out  CNT_W  saturating count of hazard stall cycles
// ----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter bit FORWARD_EN = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      id_instr,
    input  logic             id_valid,
    input  logic             ex_br_taken,
    input  logic             ext_stall,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic       writes;
        logic       is_load;
        logic [2:0] rd;
    } slot_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] sel;
    } src_res_t;

    slot_t ex_slot, mem_slot, wb_slot;
    slot_t id_slot;

    logic [3:0] opcode;
    logic [2:0] rd, rs, rt, src_b;
    logic       use_a, use_b;
    logic       hazard;
    src_res_t   res_a, res_b;

    // The low three bits are a function field the hazard logic never looks at.
    logic unused_funct;
    assign unused_funct = ^id_instr[2:0];

    assign opcode = id_instr[15:12];
    assign rd     = id_instr[11:9];
    assign rs     = id_instr[8:6];
    assign rt     = id_instr[5:3];

    // Stores and compare-type ops (1011/1100) read rd as their second operand.
    assign src_b = (opcode == 4'b1011 || opcode == 4'b1100) ? rd : rt;

    assign use_a = id_valid &&
                   ((opcode >= 4'b0001 && opcode <= 4'b1100) || opcode == 4'b1111);
    assign use_b = id_valid &&
                   ((opcode >= 4'b0001 && opcode <= 4'b1000) ||
                    opcode == 4'b1011 || opcode == 4'b1100);

    always_comb begin
        id_slot.valid   = 1'b1;
        id_slot.writes  = !(opcode == 4'b0000 || (opcode >= 4'b1011 && opcode <= 4'b1110))
                          && (rd != 3'd0);
        id_slot.is_load = (opcode == 4'b1010);
        id_slot.rd      = rd;
    end

    function automatic logic hit(input slot_t s, input logic [2:0] r);
        return s.valid && s.writes && (s.rd == r);
    endfunction

    // EX has priority over MEM over WB: the youngest producer holds the live value.
    function automatic src_res_t resolve(input logic used, input logic [2:0] r,
                                         input slot_t ex_s, input slot_t mem_s,
                                         input slot_t wb_s);
        src_res_t res;
        res = '0;
        if (used) begin
            if (FORWARD_EN) begin
                if (hit(ex_s, r)) begin
                    // Load data is not available until MEM/WB, so it cannot forward yet.
                    if (ex_s.is_load) res.stall = 1'b1;
                    else              res.sel   = 2'b01;
                end else if (hit(mem_s, r)) begin
                    res.sel = 2'b10;
                end else if (hit(wb_s, r)) begin
                    res.sel = 2'b11;
                end
            end else if (hit(ex_s, r) || hit(mem_s, r)) begin
                // WB producers need no stall: the register file writes before it reads.
                res.stall = 1'b1;
            end
        end
        return res;
    endfunction

    assign res_a  = resolve(use_a, rs,    ex_slot, mem_slot, wb_slot);
    assign res_b  = resolve(use_b, src_b, ex_slot, mem_slot, wb_slot);
    assign hazard = res_a.stall || res_b.stall;

    // Priority: reset, memory wait, taken branch (stalled ID is wrong-path), hazard.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        fwd_a_sel   = res_a.sel;
        fwd_b_sel   = res_b.sel;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            fwd_a_sel   = 2'b00;
            fwd_b_sel   = 2'b00;
        end else if (ext_stall) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
        end else if (ex_br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (hazard) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_slot   <= '0;
            mem_slot  <= '0;
            wb_slot   <= '0;
            stall_cnt <= '0;
        end else if (!ext_stall) begin
            // NOTE: non-blocking assignments let the three slots shift in one edge
            // without each stage seeing its predecessor's new value.
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            ex_slot  <= (id_valid && !idex_bubble) ? id_slot : '0;
            if (hazard && !ex_br_taken && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a forwarding instance (16-bit counter) driven from a
// vector table, and an interlock-only instance (2-bit counter, to reach
// saturation quickly) driven by a hand-written sequence. Both share inputs.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] id_instr;
    logic        id_valid;
    logic        ex_br_taken;
    logic        ext_stall;

    logic        pc_en1, ifid_en1, ifid_flush1, idex_bubble1;
    logic [1:0]  fwd_a1, fwd_b1;
    logic [15:0] cnt1;

    logic        pc_en0, ifid_en0, ifid_flush0, idex_bubble0;
    logic [1:0]  fwd_a0, fwd_b0;
    logic [1:0]  cnt0;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FORWARD_EN(1'b1), .CNT_W(16)) dut_fwd (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
        .ex_br_taken(ex_br_taken), .ext_stall(ext_stall),
        .pc_en(pc_en1), .ifid_en(ifid_en1), .ifid_flush(ifid_flush1),
        .idex_bubble(idex_bubble1), .fwd_a_sel(fwd_a1), .fwd_b_sel(fwd_b1),
        .stall_cnt(cnt1)
    );

    hazard_ctrl #(.FORWARD_EN(1'b0), .CNT_W(2)) dut_ilk (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
        .ex_br_taken(ex_br_taken), .ext_stall(ext_stall),
        .pc_en(pc_en0), .ifid_en(ifid_en0), .ifid_flush(ifid_flush0),
        .idex_bubble(idex_bubble0), .fwd_a_sel(fwd_a0), .fwd_b_sel(fwd_b0),
        .stall_cnt(cnt0)
    );

    typedef struct {
        logic [15:0] instr;
        logic        valid, br, ext;
        logic        pc, ifid, flush, bub;
        logic [1:0]  fa, fb;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[19];

    function automatic logic [15:0] mk(input int op, input int d, input int s, input int t);
        logic [3:0] o4;
        logic [2:0] d3, s3, t3;
        o4 = op[3:0];
        d3 = d[2:0];
        s3 = s[2:0];
        t3 = t[2:0];
        return {o4, d3, s3, t3, 3'b000};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] ins, input logic v, input logic br, input logic ext);
        id_instr    = ins;
        id_valid    = v;
        ex_br_taken = br;
        ext_stall   = ext;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Checks the forwarding instance's control outputs at the current time.
    task automatic chk1(input string tag, input logic pc, input logic ifid, input logic fl,
                        input logic bub, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [15:0] cnt);
        check({tag, " pc_en"},       pc_en1,       pc);
        check({tag, " ifid_en"},     ifid_en1,     ifid);
        check({tag, " ifid_flush"},  ifid_flush1,  fl);
        check({tag, " idex_bubble"}, idex_bubble1, bub);
        check({tag, " fwd_a_sel"},   fwd_a1,       fa);
        check({tag, " fwd_b_sel"},   fwd_b1,       fb);
        check({tag, " stall_cnt"},   cnt1,         cnt);
    endtask

    task automatic chk0(input string tag, input logic pc, input logic bub,
                        input logic [1:0] cnt);
        check({tag, " pc_en"},       pc_en0,       pc);
        check({tag, " ifid_en"},     ifid_en0,     pc);
        check({tag, " ifid_flush"},  ifid_flush0,  1'b0);
        check({tag, " idex_bubble"}, idex_bubble0, bub);
        check({tag, " fwd_a_sel"},   fwd_a0,       2'b00);
        check({tag, " fwd_b_sel"},   fwd_b0,       2'b00);
        check({tag, " stall_cnt"},   cnt0,         cnt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk1("reset fwd", 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 16'd0);
        check("reset ilk stall_cnt",  cnt0,        2'd0);
        check("reset ilk ifid_flush", ifid_flush0, 1'b1);
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        // instr, valid, br, ext | pc, ifid, flush, bub | fa, fb | cnt
        vecs[0]  = '{mk(1, 1, 2, 3),  1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 16'd0}; // ADD r1,r2,r3
        vecs[1]  = '{mk(2, 4, 1, 5),  1, 0, 0, 1, 1, 0, 0, 2'b01, 2'b00, 16'd0}; // SUB r4,r1,r5
        vecs[2]  = '{mk(10, 2, 0, 0), 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 16'd0}; // LOAD r2
        vecs[3]  = '{mk(1, 3, 2, 2),  1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 16'd0}; // load-use stall
        vecs[4]  = '{mk(1, 3, 2, 2),  1, 0, 0, 1, 1, 0, 0, 2'b10, 2'b10, 16'd1}; // from MEM/WB
        vecs[5]  = '{mk(11, 3, 5, 0), 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b01, 16'd1}; // STORE r3
        vecs[6]  = '{mk(1, 0, 3, 4),  1, 0, 0, 1, 1, 0, 0, 2'b10, 2'b00, 16'd1}; // ADD r0,r3,r4
        vecs[7]  = '{mk(1, 1, 0, 3),  1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b11, 16'd1}; // r0 never hits
        vecs[8]  = '{mk(1, 5, 1, 1),  0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 16'd1}; // empty slot
        vecs[9]  = '{mk(1, 5, 1, 1),  1, 0, 0, 1, 1, 0, 0, 2'b10, 2'b10, 16'd1};
        vecs[10] = '{mk(10, 6, 0, 0), 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 16'd1}; // LOAD r6
        vecs[11] = '{mk(1, 7, 6, 6),  1, 1, 0, 1, 1, 1, 1, 2'b00, 2'b00, 16'd1}; // branch wins
        vecs[12] = '{16'h0000,        0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 16'd1};
        vecs[13] = '{mk(10, 2, 0, 0), 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 16'd1}; // LOAD r2
        vecs[14] = '{mk(1, 3, 2, 1),  1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 16'd1}; // ext_stall x3
        vecs[15] = '{mk(1, 3, 2, 1),  1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 16'd1};
        vecs[16] = '{mk(1, 3, 2, 1),  1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 16'd1};
        vecs[17] = '{mk(1, 3, 2, 1),  1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 16'd1}; // stall resumes
        vecs[18] = '{mk(1, 3, 2, 1),  1, 0, 0, 1, 1, 0, 0, 2'b10, 2'b00, 16'd2};

        do_reset();

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].instr, vecs[i].valid, vecs[i].br, vecs[i].ext);
            @(negedge clk);
            chk1($sformatf("row%0d", i), vecs[i].pc, vecs[i].ifid, vecs[i].flush,
                 vecs[i].bub, vecs[i].fa, vecs[i].fb, vecs[i].cnt);
            next_cycle();
        end

        // Reset pulse in the middle of a load-use stall.
        drive(mk(10, 4, 0, 0), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk1("pre-rst load", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd2);
        next_cycle();
        drive(mk(1, 5, 4, 4), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk1("pre-rst stall", 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 16'd2);
        next_cycle();
        check("stall counted", cnt1, 16'd3);
        rst = 1'b1;
        #2;
        chk1("mid-stall rst", 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 16'd0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("post-rst", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0);
        next_cycle();

        // Interlock-only instance: EX and MEM producers stall, WB does not;
        // 2-bit counter saturates at 3.
        do_reset();
        drive(mk(1, 1, 2, 3), 1'b1, 1'b0, 1'b0);
        @(negedge clk); chk0("ilk a", 1'b1, 1'b0, 2'd0); next_cycle();
        drive(mk(1, 2, 1, 1), 1'b1, 1'b0, 1'b0);
        @(negedge clk); chk0("ilk b ex", 1'b0, 1'b1, 2'd0); next_cycle();
        @(negedge clk); chk0("ilk c mem", 1'b0, 1'b1, 2'd1); next_cycle();
        @(negedge clk); chk0("ilk d wb", 1'b1, 1'b0, 2'd2); next_cycle();
        drive(mk(1, 3, 2, 0), 1'b1, 1'b0, 1'b0);
        @(negedge clk); chk0("ilk e ex", 1'b0, 1'b1, 2'd2); next_cycle();
        @(negedge clk); chk0("ilk f mem", 1'b0, 1'b1, 2'd3); next_cycle();
        @(negedge clk); chk0("ilk g sat", 1'b1, 1'b0, 2'd3); next_cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
